// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write arbiter: default requester
// count, tag-width derivation and FIFO capacity.
package fifo_arb_pkg;

  localparam int NREQ_DEF = 3;

  // clog2(n) with a floor of one bit so a tag always exists
  function automatic int tag_width(input int n);
    int w;
    w = 0;
    for (int i = 1; i <= 8; i++) begin
      if (w == 0 && (1 << i) >= n) w = i;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // One slot stays unused so full and empty remain distinguishable
  function automatic int cap_of(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/fifo_write_arb_pick.sv
// Combinational round-robin winner selection for the FIFO write arbiter.
// FIFO_ARB_FIXED_PRIO_EN: requester 0 pre-empts the round robin of the rest.
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TW   = tag_width(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [TW-1:0]   last_grant,
  output logic [TW-1:0]   winner,
  output logic            valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    if (eligible[0]) begin
      valid = 1'b1;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = TW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arb.sv
// Credit-tracking round-robin arbiter sharing one FIFO write port among NREQ
// requesters. FIFO_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
module fifo_write_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = 6,
  parameter int AW   = 8,
  parameter int TW   = tag_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  input  logic              fifo_pop,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [W-1:0]      fifo_data,
  output logic [TW-1:0]     fifo_tag,
  output logic [AW-1:0]     credits,
  output logic              overflow_err
);

  localparam logic [AW-1:0] CAP = AW'(cap_of(AW));

  logic [NREQ-1:0] eligible;
  logic [TW-1:0]   last_grant;
  logic [TW-1:0]   pick_base;
  logic [TW-1:0]   winner;
  logic            pick_valid;
  logic            grant;

  // Masking the current ack keeps any requester from winning twice in a row
  assign eligible = req & ~ack;
  assign grant    = pick_valid && (credits != '0);

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Requesters 1..NREQ-1 rotate on their own pointer so grants to 0 do not reset it
  logic [TW-1:0] last_rr;
  assign pick_base = last_rr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_rr <= TW'(NREQ - 1);
    end else if (grant && winner != '0) begin
      last_rr <= winner;
    end
  end
`else
  assign pick_base = last_grant;
`endif

  rr_arb_pick #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (pick_base),
    .winner     (winner),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack          <= '0;
      fifo_we      <= 1'b0;
      fifo_data    <= '0;
      fifo_tag     <= '0;
      credits      <= CAP;
      last_grant   <= TW'(NREQ - 1);
      overflow_err <= 1'b0;
    end else begin
      ack     <= grant ? (NREQ'(1) << winner) : '0;
      fifo_we <= grant;
      if (grant) begin
        fifo_data  <= req_data[int'(winner)*W +: W];
        fifo_tag   <= winner;
        last_grant <= winner;
      end
      if (fifo_we && fifo_full) overflow_err <= 1'b1;
      // A pop at full capacity is dropped rather than wrapping the count
      if (grant && !fifo_pop) begin
        credits <= credits - 1'b1;
      end else if (!grant && fifo_pop && credits != CAP) begin
        credits <= credits + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arb.sv
// Directed and randomized bench for fifo_write_arb against a behavioural
// arbitration/credit model; two instances cover AW=8 and AW=2.
module tb_fifo_write_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0;
  logic [17:0] req_data = '0;
  logic        fifo_pop = 1'b0;
  logic        fifo_full = 1'b0;

  logic [2:0] ack_b, ack_s;
  logic       we_b, we_s;
  logic [5:0] data_b, data_s;
  logic [1:0] tag_b, tag_s;
  logic [7:0] cred_b;
  logic [1:0] cred_s;
  logic       ovf_b, ovf_s;

  int checks = 0;
  int failures = 0;
  int sel_small = 0;

  logic [2:0] m_ack;
  logic       m_we, m_ovf;
  logic [5:0] m_data;
  int         m_tag, m_cred, m_last, m_last_rr;

  always #5 clk = ~clk;

  fifo_write_arb #(.NREQ(3), .W(6), .AW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack_b),
    .fifo_pop(fifo_pop), .fifo_full(fifo_full), .fifo_we(we_b),
    .fifo_data(data_b), .fifo_tag(tag_b), .credits(cred_b), .overflow_err(ovf_b)
  );

  fifo_write_arb #(.NREQ(3), .W(6), .AW(2)) dut_s (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack_s),
    .fifo_pop(fifo_pop), .fifo_full(fifo_full), .fifo_we(we_s),
    .fifo_data(data_s), .fifo_tag(tag_s), .credits(cred_s), .overflow_err(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] o_ack();  return sel_small != 0 ? ack_s : ack_b; endfunction
  function automatic logic       o_we();   return sel_small != 0 ? we_s : we_b; endfunction
  function automatic logic [5:0] o_data(); return sel_small != 0 ? data_s : data_b; endfunction
  function automatic logic [1:0] o_tag();  return sel_small != 0 ? tag_s : tag_b; endfunction
  function automatic int         o_cred(); return sel_small != 0 ? int'(cred_s) : int'(cred_b); endfunction
  function automatic logic       o_ovf();  return sel_small != 0 ? ovf_s : ovf_b; endfunction

  function automatic int cap();
    return sel_small != 0 ? 3 : 255;
  endfunction

  task automatic model_reset();
    m_ack = '0; m_we = 0; m_data = '0; m_tag = 0; m_cred = cap();
    m_last = 2; m_last_rr = 2; m_ovf = 0;
  endtask

  // Arbitration rules computed directly from the requester set and credit count
  task automatic model_edge();
    logic [2:0] e;
    int w, base, c;
    bit g;
    e = req & ~m_ack;
    w = -1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    if (e[0]) w = 0;
    base = m_last_rr;
`else
    base = m_last;
`endif
    for (int k = 1; k <= 3; k++) begin
      c = (base + k) % 3;
      if (w < 0 && e[c]) w = c;
    end
    g = (w >= 0) && (m_cred > 0);
    if (m_we && fifo_full) m_ovf = 1;
    if (g && !fifo_pop) m_cred--;
    else if (!g && fifo_pop && m_cred < cap()) m_cred++;
    m_we = g;
    m_ack = '0;
    if (g) begin
      m_ack[w] = 1'b1;
      m_data = req_data[w*6 +: 6];
      m_tag = w;
      m_last = w;
      if (w != 0) m_last_rr = w;
    end
  endtask

  task automatic check_all();
    chk("ack", 32'(o_ack()), 32'(m_ack));
    chk("fifo_we", 32'(o_we()), 32'(m_we));
    chk("fifo_data", 32'(o_data()), 32'(m_data));
    chk("fifo_tag", 32'(o_tag()), 32'(m_tag));
    chk("credits", 32'(o_cred()), 32'(m_cred));
    chk("overflow_err", 32'(o_ovf()), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_order[6];
  int grants;
  logic [2:0] prev_ack;

  initial begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
    exp_order = '{0, 1, 0, 2, 0, 1};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    #2;
    do_reset();
    chk("reset_credits", 32'(cred_b), 32'd255);

    // single requester, first-grant latency
    req = 3'b001; req_data = {6'h00, 6'h00, 6'h15};
    step();
    chk("single_ack", 32'(ack_b), 32'h1);
    chk("single_data", 32'(data_b), 32'h15);
    chk("single_credits", 32'(cred_b), 32'd254);
    req = '0;
    step();

    // round-robin order with all three requesting
    do_reset();
    req = 3'b111; req_data = {6'h33, 6'h22, 6'h11};
    prev_ack = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_order", 32'(tag_b), 32'(exp_order[i]));
      chk("rr_we", 32'(we_b), 32'd1);
      chk("no_back_to_back", 32'(ack_b & prev_ack), 32'd0);
      prev_ack = ack_b;
    end
    req = '0;
    step();

    // credit exhaustion on the AW=2 instance
    sel_small = 1;
    do_reset();
    req = 3'b111;
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (we_s) grants++;
    end
    chk("cap_grants", 32'(grants), 32'd3);
    chk("cap_credits_zero", 32'(cred_s), 32'd0);
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    grants = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (we_s) grants++;
    end
    chk("pop_one_grant", 32'(grants), 32'd1);
    req = '0; fifo_pop = 1'b1;
    step(); step();
    chk("credits_two", 32'(cred_s), 32'd2);
    req = 3'b001;
    step();
    chk("grant_and_pop", 32'(cred_s), 32'd2);
    req = '0;
    step(); step();
    chk("pop_saturate", 32'(cred_s), 32'd3);
    fifo_pop = 1'b0;

    // overflow detection and stickiness
    sel_small = 0;
    do_reset();
    req = 3'b111; fifo_full = 1'b1;
    step(); step();
    chk("overflow_set", 32'(ovf_b), 32'd1);
    fifo_full = 1'b0; req = '0;
    step(); step(); step();
    chk("overflow_sticky", 32'(ovf_b), 32'd1);

    // asynchronous reset in the middle of a burst
    req = 3'b111;
    step(); step();
    @(posedge clk);
    model_edge();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("midburst_we", 32'(we_b), 32'd0);
    chk("midburst_ovf", 32'(ovf_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel_small = s;
      do_reset();
      for (int i = 0; i < 400; i++) begin
        req = 3'($urandom_range(0, 7));
        req_data = 18'($urandom);
        fifo_pop = ($urandom_range(0, 2) == 0);
        fifo_full = ($urandom_range(0, 29) == 0);
        step();
      end
      req = '0; fifo_pop = 1'b0; fifo_full = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arb.md
FIFO_WRITE_ARB -- requirements
Module: fifo_write_arb

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing one FIFO write port; range 2..4.
REQ-002 Parameter W, default 6: data width, equal to the FIFO data width.
REQ-003 Parameter AW, default 8: FIFO address width; capacity CAP = 2**AW - 1 entries (one slot always unused).
REQ-004 Parameter TW, default 2: tag width, clog2(NREQ) with minimum 1.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  NREQ  per-requester write request, level.
REQ-008 req_data  input  NREQ*W  requester i data in bits [i*W +: W].
REQ-009 ack  output  NREQ  registered one-hot, one-cycle grant pulse.
REQ-010 fifo_pop  input  1  pulse when the consumer actually removes an entry (RE and not empty).
REQ-011 fifo_full  input  1  FIFO full flag; used only for error detection.
REQ-012 fifo_we  output  1  registered FIFO write enable.
REQ-013 fifo_data  output  W  registered FIFO write data.
REQ-014 fifo_tag  output  TW  index of the requester whose data is on fifo_data.
REQ-015 credits  output  AW  free FIFO entries as tracked by the arbiter.
REQ-016 overflow_err  output  1  sticky error flag.

Function
REQ-017 The requester set is eligible = req AND NOT ack, so a requester is never granted on two consecutive cycles.
REQ-018 A grant issues at an edge only when eligible is nonzero and credits > 0.
REQ-019 The winner is the first eligible index after last_grant, searching upward modulo NREQ (round robin).
REQ-020 On a grant to index g at edge e, in the cycle after e: ack[g]=1, fifo_we=1, fifo_data=req_data[g] sampled at e, fifo_tag=g, and last_grant becomes g.
REQ-021 Latency is one edge, from req sampled high to ack and fifo_we high.
REQ-022 With no grant, ack and fifo_we are 0 in the following cycle; fifo_data and fifo_tag hold their values.
REQ-023 Requesters update req and req_data at the edge where ack is sampled high; data must be stable from req assertion until that edge.
REQ-024 Credit update per edge: grant only gives credits-1; fifo_pop only gives credits+1; both or neither leaves credits unchanged.
REQ-025 Credits saturate at CAP; a fifo_pop at credits==CAP is ignored and does not wrap.
REQ-026 At credits==0, no grant issues; requests stay pending and none are dropped.
REQ-027 overflow_err sets when fifo_we=1 and fifo_full=1 in the same cycle, and clears only on reset.
REQ-028 Sustained throughput is one write per cycle when two or more requesters are active.

Reset
REQ-029 Asynchronous reset sets: ack=0, fifo_we=0, fifo_data=0, fifo_tag=0, credits=CAP, last_grant=NREQ-1 (requester 0 wins first), overflow_err=0.
REQ-030 A grant in flight when reset asserts is discarded; the requester re-requests after reset.

Configuration
REQ-031 With FIFO_ARB_FIXED_PRIO_EN defined, requester 0 wins whenever eligible, and the remaining requesters are round robin among themselves.
REQ-032 Without FIFO_ARB_FIXED_PRIO_EN, all NREQ requesters use pure round robin.

Structure
REQ-033 Package fifo_arb_pkg holds NREQ default, the TW derivation function, and the CAP calculation.
REQ-034 Sub-module rr_arb_pick is combinational: inputs eligible and last_grant; outputs winner index and a valid flag; it contains the fixed-priority option.

Verification
REQ-035 Reset, then req=3'b001, data0=6'h15 -> ack=3'b001 and fifo_we=1, fifo_data=6'h15, fifo_tag=0 one cycle later; credits=254.
REQ-036 req=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2; fifo_we high every cycle; no requester granted back-to-back.
REQ-037 AW=2 (CAP=3), 5 writes with no pops -> 3 grants, then credits=0 and req pending; one fifo_pop -> exactly one further grant.
REQ-038 Grant and fifo_pop on the same edge at credits=2 -> credits stays 2; fifo_pop at credits=CAP -> credits stays CAP.
REQ-039 With FIFO_ARB_FIXED_PRIO_EN defined, req=3'b111 held with requester 0 re-requesting after each ack -> 0,1,0,2,0,1 order.
REQ-040 Force fifo_full=1 while fifo_we=1 -> overflow_err=1 and it remains set until reset; reset asserted mid-burst -> all outputs return to their reset values immediately.
